// File: rtl/cpu7_ifu_fcl.sv
// cpu7 IFU fetch control: icache handshake, pc_bf select, stale-response
// discard after redirect and the one-entry decode hold buffer.
module cpu7_ifu_fcl (
  input  logic clock,
  input  logic reset,
  input  logic inst_addr_ok,
  input  logic inst_valid,
  input  logic br_cancel,
  input  logic dec_fcl_stall,
  output logic inst_req,
  output logic inst_cancel,
  output logic fcl_fdp_pcbf_sel_init_bf_l,
  output logic fcl_fdp_pcbf_sel_old_bf_l,
  output logic fcl_fdp_pcbf_sel_pcinc_bf_l,
  output logic fcl_fdp_pcbf_sel_brpc_bf_l,
  output logic fcl_fdp_ibuf_we,
  output logic fcl_fdp_ibuf_sel,
  output logic fcl_dec_valid
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e state_q, state_d;
  logic   req;
  logic   dv;
  logic   we;
  logic   ibsel;
  logic   handoff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    dv      = 1'b0;
    we      = 1'b0;
    ibsel   = 1'b0;
    handoff = 1'b0;
    unique case (state_q)
      S_REQ: begin
        req = 1'b1;
        if (!br_cancel && inst_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (br_cancel) begin
          state_d = inst_valid ? S_REQ : S_DROP;
        end else if (inst_valid) begin
          dv = 1'b1;
          if (dec_fcl_stall) begin
            we      = 1'b1;
            state_d = S_HOLD;
          end else begin
            handoff = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: begin
        ibsel = 1'b1;
        if (br_cancel) begin
          state_d = S_REQ;
        end else begin
          dv = 1'b1;
          if (!dec_fcl_stall) begin
            handoff = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_DROP: begin
        // the owed stale response retires DROP, a new redirect does not
        if (inst_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  assign inst_req         = req & ~reset;
  assign inst_cancel      = br_cancel & ~reset;
  assign fcl_dec_valid    = dv & ~reset;
  assign fcl_fdp_ibuf_we  = we & ~reset;
  assign fcl_fdp_ibuf_sel = ibsel & ~reset;

  assign fcl_fdp_pcbf_sel_init_bf_l  = ~reset;
  assign fcl_fdp_pcbf_sel_brpc_bf_l  = ~(~reset & br_cancel);
  assign fcl_fdp_pcbf_sel_pcinc_bf_l = ~(~reset & ~br_cancel & handoff);
  assign fcl_fdp_pcbf_sel_old_bf_l   = ~(~reset & ~br_cancel & ~handoff);

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Bench for cpu7_ifu_fcl: fixed vector table, pc tracking sequences and
// random stimulus against a flag-based reference model.
module tb_cpu7_ifu_fcl;

  localparam logic [31:0] PC_INIT = 32'h1c00_0000;

  logic clock = 1'b0;
  logic reset, inst_addr_ok, inst_valid, br_cancel, dec_fcl_stall;
  logic inst_req, inst_cancel;
  logic sel_init_l, sel_old_l, sel_pcinc_l, sel_brpc_l;
  logic ibuf_we, ibuf_sel, dec_valid;
  logic [8:0] o;

  always #5 clock = ~clock;

  cpu7_ifu_fcl dut (
    .clock                       (clock),
    .reset                       (reset),
    .inst_addr_ok                (inst_addr_ok),
    .inst_valid                  (inst_valid),
    .br_cancel                   (br_cancel),
    .dec_fcl_stall               (dec_fcl_stall),
    .inst_req                    (inst_req),
    .inst_cancel                 (inst_cancel),
    .fcl_fdp_pcbf_sel_init_bf_l  (sel_init_l),
    .fcl_fdp_pcbf_sel_old_bf_l   (sel_old_l),
    .fcl_fdp_pcbf_sel_pcinc_bf_l (sel_pcinc_l),
    .fcl_fdp_pcbf_sel_brpc_bf_l  (sel_brpc_l),
    .fcl_fdp_ibuf_we             (ibuf_we),
    .fcl_fdp_ibuf_sel            (ibuf_sel),
    .fcl_dec_valid               (dec_valid)
  );

  // [8]req [7]cancel [6]init_l [5]old_l [4]pcinc_l [3]brpc_l
  // [2]ibuf_we [1]ibuf_sel [0]dec_valid
  assign o = {inst_req, inst_cancel, sel_init_l, sel_old_l,
              sel_pcinc_l, sel_brpc_l, ibuf_we, ibuf_sel, dec_valid};

  localparam logic [8:0] RST  = 9'b000111000;
  localparam logic [8:0] RQ   = 9'b101011000;
  localparam logic [8:0] IDL  = 9'b001011000;
  localparam logic [8:0] DLV  = 9'b001101001;
  localparam logic [8:0] DLS  = 9'b001011101;
  localparam logic [8:0] HST  = 9'b001011011;
  localparam logic [8:0] HRL  = 9'b001101011;
  localparam logic [8:0] HCN  = 9'b011110010;
  localparam logic [8:0] CN   = 9'b011110000;
  localparam logic [8:0] RQCN = 9'b111110000;

  int vectors = 0;
  int miscompares = 0;

  // reference model: which kind of response we are waiting on, if any
  bit m_busy, m_stale, m_held;
  logic [31:0] pc_f, pc_at, br_tgt;
  logic [8:0]  last_o;

  task automatic cmp(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [8:0] model_out(input bit r, v, b, s);
    bit idle, handoff, dv, we;
    logic [8:0] e;
    if (r) return RST;
    idle    = !m_busy && !m_stale && !m_held;
    handoff = !b && ((m_busy && v && !s) || (m_held && !s));
    dv      = !b && ((m_busy && v) || m_held);
    we      = !b && m_busy && v && s;
    e = {idle, b, 1'b1, 1'b1, 1'b1, 1'b1, we, m_held, dv};
    if (b)            e[3] = 1'b0;
    else if (handoff) e[4] = 1'b0;
    else              e[5] = 1'b0;
    return e;
  endfunction

  task automatic model_step(input bit r, a, v, b, s);
    bit idle;
    idle = !m_busy && !m_stale && !m_held;
    if (r) begin
      m_busy = 0; m_stale = 0; m_held = 0;
    end else if (idle) begin
      m_busy = a && !b;
    end else if (m_busy) begin
      if (b) begin
        m_busy = 0; m_stale = !v;
      end else if (v) begin
        m_busy = 0; m_held = s;
      end
    end else if (m_held) begin
      if (b || !s) m_held = 0;
    end else if (v) begin
      m_stale = 0;
    end
  endtask

  task automatic cyc(input bit r, a, v, b, s);
    logic [8:0] e;
    @(negedge clock);
    reset = r; inst_addr_ok = a; inst_valid = v;
    br_cancel = b; dec_fcl_stall = s;
    #1;
    e = model_out(r, v, b, s);
    cmp("model", {23'd0, o}, {23'd0, e});
    cmp("onehot", $countones(~o[6:3]), 1);
    last_o = o;
    pc_at  = pc_f;
    @(posedge clock);
    model_step(r, a, v, b, s);
    if (!last_o[6])      pc_f = PC_INIT;
    else if (!last_o[3]) pc_f = br_tgt;
    else if (!last_o[4]) pc_f = pc_f + 32'd4;
  endtask

  typedef struct {
    bit r, a, v, b, s;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, a, v, b, s,
                              input logic [8:0] e);
    vec_t t;
    t.r = r; t.a = a; t.v = v; t.b = b; t.s = s; t.exp = e;
    return t;
  endfunction

  initial begin
    reset = 1; inst_addr_ok = 0; inst_valid = 0;
    br_cancel = 0; dec_fcl_stall = 0;
    pc_f = PC_INIT; br_tgt = 32'h1c00_0040;
    m_busy = 0; m_stale = 0; m_held = 0;

    tbl.push_back(mk(1,0,0,0,0, RST));
    tbl.push_back(mk(1,1,0,1,0, RST));
    tbl.push_back(mk(1,1,1,0,1, RST));
    tbl.push_back(mk(0,0,0,0,0, RQ));
    tbl.push_back(mk(0,1,0,0,0, RQ));
    tbl.push_back(mk(0,0,1,0,0, DLV));
    tbl.push_back(mk(0,1,0,0,0, RQ));
    tbl.push_back(mk(0,0,1,0,0, DLV));
    tbl.push_back(mk(0,1,0,0,0, RQ));
    tbl.push_back(mk(0,0,0,0,0, IDL));
    tbl.push_back(mk(0,0,1,0,1, DLS));
    tbl.push_back(mk(0,0,0,0,1, HST));
    tbl.push_back(mk(0,0,0,0,1, HST));
    tbl.push_back(mk(0,0,0,0,0, HRL));
    tbl.push_back(mk(0,1,0,0,0, RQ));
    tbl.push_back(mk(0,0,0,1,0, CN));
    tbl.push_back(mk(0,1,0,0,0, IDL));
    tbl.push_back(mk(0,0,1,0,0, IDL));
    tbl.push_back(mk(0,1,0,1,0, RQCN));
    tbl.push_back(mk(0,0,0,0,0, RQ));
    tbl.push_back(mk(0,1,0,0,0, RQ));
    tbl.push_back(mk(0,0,1,0,1, DLS));
    tbl.push_back(mk(0,0,0,1,1, HCN));
    tbl.push_back(mk(0,0,0,0,0, RQ));
    tbl.push_back(mk(0,0,1,0,0, RQ));
    tbl.push_back(mk(0,1,0,0,0, RQ));
    tbl.push_back(mk(0,0,1,1,0, CN));
    tbl.push_back(mk(0,0,0,0,0, RQ));
    tbl.push_back(mk(0,1,0,0,0, RQ));
    tbl.push_back(mk(0,0,0,1,0, CN));
    tbl.push_back(mk(0,0,0,1,0, CN));
    tbl.push_back(mk(0,0,1,1,0, CN));
    tbl.push_back(mk(0,0,0,0,0, RQ));
    tbl.push_back(mk(0,1,0,0,0, RQ));
    tbl.push_back(mk(1,0,0,0,0, RST));
    tbl.push_back(mk(0,0,0,0,0, RQ));

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].a, tbl[i].v, tbl[i].b, tbl[i].s);
      cmp($sformatf("tbl%0d", i), {23'd0, last_o}, {23'd0, tbl[i].exp});
    end

    // reset release then straight-line fetch with pc tracking
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 0);
      cmp("sl_req", {31'd0, last_o[8]}, 1);
      cmp("sl_old", {31'd0, last_o[5]}, 0);
      cmp("sl_reqpc", pc_at, PC_INIT + 32'(4 * k));
      cyc(0, 0, 1, 0, 0);
      cmp("sl_dv", {31'd0, last_o[0]}, 1);
      cmp("sl_pcinc", {31'd0, last_o[4]}, 0);
      cmp("sl_dvpc", pc_at, PC_INIT + 32'(4 * k));
    end

    // redirect in WAIT followed by a stale response
    cyc(0, 1, 0, 0, 0);
    br_tgt = 32'h1c00_0100;
    cyc(0, 0, 0, 1, 0);
    cmp("rd_cancel", {31'd0, last_o[7]}, 1);
    cmp("rd_brpc", {31'd0, last_o[3]}, 0);
    cyc(0, 0, 0, 0, 0);
    cmp("rd_drop_noreq", {31'd0, last_o[8]}, 0);
    cyc(0, 0, 1, 0, 0);
    cmp("rd_stale_dv", {31'd0, last_o[0]}, 0);
    cyc(0, 0, 0, 0, 0);
    cmp("rd_req", {31'd0, last_o[8]}, 1);
    cmp("rd_reqpc", pc_at, 32'h1c00_0100);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      br_tgt = {$urandom_range(32'h3fff_ffff, 0), 2'b00};
      cyc($urandom_range(49, 0) == 0, $urandom_range(1, 0) == 1,
          $urandom_range(1, 0) == 1, $urandom_range(7, 0) == 0,
          $urandom_range(2, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
